simple_bus_slave: RTL and testbench
===================================

Name: simple_bus_slave

Overview:
- Memory-backed responder on the simple request/grant bus; drives gnt, rdata, rvalid, intr and viral_state back to the bus driver.
- Sits directly downstream of the bus driver and implements the full slave side of the handshake.
- Contents: a word-addressed register file, one interrupt CSR, and a sticky error ("viral") state.

Parameters:
- DEPTH, 64: number of 32-bit storage words, power of 2, 2..1024.
- GNT_DELAY, 0: extra wait cycles between seeing req and asserting gnt, 0..15.
- RD_LATENCY, 1: cycles from the read capture edge to rvalid, 1..8.
- INTR_ADDR, 32'h0000_FFF0: byte address of the interrupt CSR; must lie outside 0..DEPTH*4-1.

Ports:
- clk  in  1  bus clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  request; held high by the driver until it samples gnt=1.
- we  in  1  write enable.
- waddr  in  32  write byte address.
- wdata  in  32  write data.
- re  in  1  read enable.
- raddr  in  32  read byte address.
- gnt  out  1  grant, one-cycle pulse.
- rdata  out  32  read data, valid only while rvalid=1.
- rvalid  out  1  read response strobe, one-cycle pulse.
- intr  out  1  interrupt, level.
- viral_state  out  1  sticky error flag.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: gnt=0, rdata=0, rvalid=0, intr=0, viral_state=0, all storage words=0, FSM=IDLE, counters=0.
- Reset mid-transaction: the block returns to IDLE immediately. Any pending read is dropped and no rvalid is produced after reset.
- Addressing: word index = addr[log2(DEPTH)+1:2]. An access is in range when addr < DEPTH*4 and addr[1:0]=0. Access to INTR_ADDR is legal.
- FSM states: IDLE, WAIT, GRANT, READ.
- IDLE:
  - req=1 at an edge -> WAIT if GNT_DELAY>0, otherwise GRANT.
  - req=0 -> stay in IDLE.
- WAIT: counts GNT_DELAY cycles, then -> GRANT. req dropping during WAIT is a driver protocol error; the FSM still completes GRANT and ignores the fields.
- GRANT:
  - gnt=1 for exactly this cycle.
  - The edge ending GRANT is the capture edge: we, re, addresses and wdata are sampled there.
  - Read -> READ. Write or no-op -> IDLE.
- Request latency: with GNT_DELAY=0, gnt is high in the cycle immediately after the edge where req is first seen. Each GNT_DELAY cycle adds one cycle.
- Write (we=1, re=0), committed at the capture edge:
  - In range: store wdata.
  - waddr=INTR_ADDR: wdata!=0 sets intr; wdata=0 has no effect.
  - Anything else: error.
- Read (re=1, we=0):
  - rvalid=1 and rdata driven for one cycle, RD_LATENCY cycles after the capture edge (RD_LATENCY=1 means the very next cycle); then -> IDLE.
  - rdata = stored word for an in-range address.
  - rdata = {31'b0, intr} for INTR_ADDR; this read also clears intr on the rvalid edge.
  - Out of range: rdata=32'hDEAD_BEEF and error.
- Error cases:
  - we=1 and re=1 at capture: error, treated as a read, no write performed.
  - we=0 and re=0 at capture: no-op, no error.
- Error effect: viral_state=1 from the cycle after the capture edge, sticky until rst.
- While viral_state=1:
  - gnt protocol continues unchanged.
  - All writes are dropped; the intr CSR is still writable.
  - All reads return 32'hDEAD_BEEF.
- Back-to-back transactions: req=1 in the first IDLE cycle after a transaction starts a new one. Minimum spacing: 2 cycles between gnt pulses for writes, 2+RD_LATENCY for reads.
- Write/read ordering: a read issued after a write to the same address returns the new data; writes commit before the next transaction is granted.
- intr set and clear in the same cycle cannot occur, since transactions are serialized.

Optional Feature:
- Macro SIMPLE_BUS_SLAVE_ERR_INTR_EN.
- Defined: any error also sets intr in the same cycle viral_state rises. intr is cleared by an INTR_ADDR read as usual; viral_state stays set.
- Undefined: errors affect viral_state only.

Test Plan:
- Reset, then write 32'hCAFE_0001 to 0x8, then read 0x8 (defaults) -> gnt one cycle after each req; rvalid in the cycle after the read capture with rdata=32'hCAFE_0001; viral_state=0.
- GNT_DELAY=3, RD_LATENCY=4: read 0x0 after reset -> gnt exactly 4 cycles after req first seen; rvalid 4 cycles after capture; rdata=0.
- Write 1 to INTR_ADDR -> intr=1. Read INTR_ADDR -> rdata=1 and intr=0 after rvalid. A second read returns 0.
- Read 0x100 with DEPTH=64 -> rdata=32'hDEAD_BEEF, viral_state=1. A following write of 5 to 0x4 is dropped, and a read of 0x4 returns 32'hDEAD_BEEF. With SIMPLE_BUS_SLAVE_ERR_INTR_EN defined, intr=1.
- we=1 and re=1 at address 0xC -> viral_state=1, rvalid pulses, and storage at 0xC is unchanged (verify after rst via backdoor or fresh read pre-error).
- Assert rst during READ with RD_LATENCY=8 -> no rvalid is ever produced; all outputs are 0 the same cycle; the next req is granted normally.

Source files
------------

// File: rtl/simple_bus_slave.sv
// Memory-backed slave for the req/gnt bus: word register file, interrupt CSR and sticky viral error flag.
// Optional macro SIMPLE_BUS_SLAVE_ERR_INTR_EN: any bus error also raises intr.
module simple_bus_slave #(
  parameter int          DEPTH      = 64,
  parameter int          GNT_DELAY  = 0,
  parameter int          RD_LATENCY = 1,
  parameter logic [31:0] INTR_ADDR  = 32'h0000_FFF0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] waddr,
  input  logic [31:0] wdata,
  input  logic        re,
  input  logic [31:0] raddr,
  output logic        gnt,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        intr,
  output logic        viral_state
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [31:0] BYTES    = 32'(DEPTH * 4);
  localparam logic [31:0] BAD_DATA = 32'hDEAD_BEEF;
  localparam logic [3:0]  GNT_LAST = 4'(GNT_DELAY - 1);
  localparam logic [3:0]  RD_LAST  = 4'(RD_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, GRANT, READ} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_reg;
  logic        rd_intr_reg;
  logic        intr_reg;
  logic        viral_reg;

  // One shared counter: grant wait cycles in WAIT, read latency in READ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          cnt_next   = '0;
          state_next = (GNT_DELAY > 0) ? WAIT : GRANT;
        end
      end
      WAIT: begin
        if (cnt == GNT_LAST) state_next = GRANT;
        else                 cnt_next   = cnt + 4'd1;
      end
      GRANT: begin
        cnt_next   = '0;
        state_next = re ? READ : IDLE;
      end
      READ: begin
        if (cnt == RD_LAST) state_next = IDLE;
        else                cnt_next   = cnt + 4'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  logic          capture;
  logic          wr_intr, wr_in_range, rd_intr, rd_in_range;
  logic          err_now;
  logic [AW-1:0] widx, ridx;

  assign capture     = (state == GRANT);
  assign wr_intr     = (waddr == INTR_ADDR);
  assign rd_intr     = (raddr == INTR_ADDR);
  assign wr_in_range = (waddr < BYTES) && (waddr[1:0] == 2'b00);
  assign rd_in_range = (raddr < BYTES) && (raddr[1:0] == 2'b00);
  assign widx        = waddr[AW+1:2];
  assign ridx        = raddr[AW+1:2];
  // A simultaneous we/re is a read that is also an error.
  assign err_now     = re ? (we || (!rd_intr && !rd_in_range))
                          : (we && !wr_intr && !wr_in_range);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata_reg   <= '0;
      rd_intr_reg <= 1'b0;
      intr_reg    <= 1'b0;
      viral_reg   <= 1'b0;
    end else begin
      if (rvalid && rd_intr_reg) intr_reg <= 1'b0;
      if (capture) begin
        if (err_now) viral_reg <= 1'b1;
`ifdef SIMPLE_BUS_SLAVE_ERR_INTR_EN
        if (err_now) intr_reg <= 1'b1;
`endif
        if (we && !re) begin
          if (wr_intr) begin
            if (wdata != 32'd0) intr_reg <= 1'b1;
          end else if (wr_in_range && !viral_reg) begin
            mem[widx] <= wdata;
          end
        end
        if (re) begin
          rd_intr_reg <= rd_intr && !we;
          if (viral_reg || err_now) rdata_reg <= BAD_DATA;
          else if (rd_intr)         rdata_reg <= {31'b0, intr_reg};
          else                      rdata_reg <= mem[ridx];
        end
      end
    end
  end

  assign gnt         = (state == GRANT);
  assign rvalid      = (state == READ) && (cnt == RD_LAST);
  assign rdata       = rvalid ? rdata_reg : 32'd0;
  assign intr        = intr_reg;
  assign viral_state = viral_reg;
endmodule

// File: tb/tb_simple_bus_slave.sv
// Directed bench: three slave instances (default timing, slow grant/read, long read latency).
module tb_simple_bus_slave;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req [3];
  logic        we [3];
  logic        re [3];
  logic [31:0] waddr [3];
  logic [31:0] wdata [3];
  logic [31:0] raddr [3];
  logic [31:0] rdata [3];
  logic        gnt [3];
  logic        rvalid [3];
  logic        intr [3];
  logic        viral [3];

`ifdef SIMPLE_BUS_SLAVE_ERR_INTR_EN
  localparam bit EI = 1'b1;
`else
  localparam bit EI = 1'b0;
`endif

  simple_bus_slave u0 (
    .clk(clk), .rst(rst), .req(req[0]), .we(we[0]), .waddr(waddr[0]), .wdata(wdata[0]),
    .re(re[0]), .raddr(raddr[0]), .gnt(gnt[0]), .rdata(rdata[0]), .rvalid(rvalid[0]),
    .intr(intr[0]), .viral_state(viral[0]));

  simple_bus_slave #(.GNT_DELAY(3), .RD_LATENCY(4)) u1 (
    .clk(clk), .rst(rst), .req(req[1]), .we(we[1]), .waddr(waddr[1]), .wdata(wdata[1]),
    .re(re[1]), .raddr(raddr[1]), .gnt(gnt[1]), .rdata(rdata[1]), .rvalid(rvalid[1]),
    .intr(intr[1]), .viral_state(viral[1]));

  simple_bus_slave #(.RD_LATENCY(8)) u2 (
    .clk(clk), .rst(rst), .req(req[2]), .we(we[2]), .waddr(waddr[2]), .wdata(wdata[2]),
    .re(re[2]), .raddr(raddr[2]), .gnt(gnt[2]), .rdata(rdata[2]), .rvalid(rvalid[2]),
    .intr(intr[2]), .viral_state(viral[2]));

  typedef struct {
    string       name;
    int          k;
    bit          w;
    bit          r;
    logic [31:0] wa;
    logic [31:0] wd;
    logic [31:0] ra;
    bit          chk_rd;
    logic [31:0] exp_rd;
    int          exp_glat;
    int          exp_rlat;
    bit          exp_viral;
    bit          exp_intr;
  } vec_t;

  vec_t vecs [$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string n, input int k, input bit w, input bit r,
                     input logic [31:0] wa, input logic [31:0] wd, input logic [31:0] ra,
                     input bit chk, input logic [31:0] erd, input int gl, input int rl,
                     input bit ev, input bit eint);
    vec_t v;
    v.name = n; v.k = k; v.w = w; v.r = r; v.wa = wa; v.wd = wd; v.ra = ra;
    v.chk_rd = chk; v.exp_rd = erd; v.exp_glat = gl; v.exp_rlat = rl;
    v.exp_viral = ev; v.exp_intr = eint;
    vecs.push_back(v);
  endtask

  // Drives one transaction; latencies are -1 when the bounded wait expires.
  task automatic txn(input int k, input bit w, input bit r, input logic [31:0] wa,
                     input logic [31:0] wd, input logic [31:0] ra,
                     output int glat, output int rlat, output logic [31:0] rd);
    glat = 0; rlat = 0; rd = '0;
    req[k] = 1'b1; we[k] = w; re[k] = r; waddr[k] = wa; wdata[k] = wd; raddr[k] = ra;
    do begin
      step();
      glat++;
    end while (!gnt[k] && glat < 40);
    if (!gnt[k]) begin
      glat = -1;
      req[k] = 1'b0; we[k] = 1'b0; re[k] = 1'b0;
      return;
    end
    step();
    req[k] = 1'b0; we[k] = 1'b0; re[k] = 1'b0;
    check($sformatf("gnt_pulse_u%0d", k), {31'b0, gnt[k]}, 32'd0);
    if (r) begin
      rlat = 1;
      while (!rvalid[k] && rlat < 20) begin
        step();
        rlat++;
      end
      if (!rvalid[k]) begin
        rlat = -1;
      end else begin
        rd = rdata[k];
        step();
        check($sformatf("rvalid_pulse_u%0d", k), {31'b0, rvalid[k]}, 32'd0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          glat, rlat;
    logic [31:0] rd;
    bit          seen;

    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; re[i] = 1'b0;
      waddr[i] = '0; wdata[i] = '0; raddr[i] = '0;
    end

    // u0: default timing, functional sweep then error cases
    add("wr_8",        0, 1, 0, 32'h8,    32'hCAFE_0001, 32'h0,    0, 32'h0,          1, 0, 0, 0);
    add("rd_8",        0, 0, 1, 32'h0,    32'h0,         32'h8,    1, 32'hCAFE_0001,  1, 1, 0, 0);
    add("wr_c",        0, 1, 0, 32'hC,    32'h1234_5678, 32'h0,    0, 32'h0,          1, 0, 0, 0);
    add("rd_c",        0, 0, 1, 32'h0,    32'h0,         32'hC,    1, 32'h1234_5678,  1, 1, 0, 0);
    add("wr_last",     0, 1, 0, 32'hFC,   32'hAAAA_5555, 32'h0,    0, 32'h0,          1, 0, 0, 0);
    add("rd_last",     0, 0, 1, 32'h0,    32'h0,         32'hFC,   1, 32'hAAAA_5555,  1, 1, 0, 0);
    add("wr_intr_0",   0, 1, 0, 32'hFFF0, 32'h0,         32'h0,    0, 32'h0,          1, 0, 0, 0);
    add("wr_intr_1",   0, 1, 0, 32'hFFF0, 32'h1,         32'h0,    0, 32'h0,          1, 0, 0, 1);
    add("rd_intr_1",   0, 0, 1, 32'h0,    32'h0,         32'hFFF0, 1, 32'h1,          1, 1, 0, 0);
    add("rd_intr_0",   0, 0, 1, 32'h0,    32'h0,         32'hFFF0, 1, 32'h0,          1, 1, 0, 0);
    add("rd_unwrit",   0, 0, 1, 32'h0,    32'h0,         32'h4,    1, 32'h0,          1, 1, 0, 0);
    add("we_re_c",     0, 1, 1, 32'hC,    32'hFFFF_FFFF, 32'hC,    0, 32'h0,          1, 1, 1, EI);
    add("wr_8_viral",  0, 1, 0, 32'h8,    32'h77,        32'h0,    0, 32'h0,          1, 0, 1, EI);
    add("rd_8_viral",  0, 0, 1, 32'h0,    32'h0,         32'h8,    1, 32'hDEAD_BEEF,  1, 1, 1, EI);
    // u1: GNT_DELAY=3, RD_LATENCY=4
    add("u1_rd_0",     1, 0, 1, 32'h0,    32'h0,         32'h0,    1, 32'h0,          4, 4, 0, 0);
    add("u1_wr_0",     1, 1, 0, 32'h0,    32'h1111_1111, 32'h0,    0, 32'h0,          4, 0, 0, 0);
    add("u1_rd_0b",    1, 0, 1, 32'h0,    32'h0,         32'h0,    1, 32'h1111_1111,  4, 4, 0, 0);
    add("u1_rd_oor",   1, 0, 1, 32'h0,    32'h0,         32'h100,  1, 32'hDEAD_BEEF,  4, 4, 1, EI);
    add("u1_wr_4",     1, 1, 0, 32'h4,    32'h5,         32'h0,    0, 32'h0,          4, 0, 1, EI);
    add("u1_rd_4",     1, 0, 1, 32'h0,    32'h0,         32'h4,    1, 32'hDEAD_BEEF,  4, 4, 1, EI);
    add("u1_rd_intr",  1, 0, 1, 32'h0,    32'h0,         32'hFFF0, 1, 32'hDEAD_BEEF,  4, 4, 1, 0);
    add("u1_wr_intr",  1, 1, 0, 32'hFFF0, 32'h8,         32'h0,    0, 32'h0,          4, 0, 1, 1);
    // u2: misaligned write is an error
    add("u2_wr_mis",   2, 1, 0, 32'h2,    32'h9,         32'h0,    0, 32'h0,          1, 0, 1, EI);

    repeat (2) step();
    check("rst_gnt",    {31'b0, gnt[0]},    32'd0);
    check("rst_rvalid", {31'b0, rvalid[0]}, 32'd0);
    check("rst_rdata",  rdata[0],           32'd0);
    check("rst_intr",   {31'b0, intr[0]},   32'd0);
    check("rst_viral",  {31'b0, viral[0]},  32'd0);
    rst = 1'b0;
    step();

    foreach (vecs[i]) begin
      txn(vecs[i].k, vecs[i].w, vecs[i].r, vecs[i].wa, vecs[i].wd, vecs[i].ra, glat, rlat, rd);
      $display("[TB] %s: u%0d we=%0b re=%0b glat=%0d rlat=%0d rdata=%h viral=%0b intr=%0b",
               vecs[i].name, vecs[i].k, vecs[i].w, vecs[i].r, glat, rlat, rd,
               viral[vecs[i].k], intr[vecs[i].k]);
      check({vecs[i].name, "_glat"}, 32'(glat), 32'(vecs[i].exp_glat));
      check({vecs[i].name, "_rlat"}, 32'(rlat), 32'(vecs[i].exp_rlat));
      if (vecs[i].chk_rd) check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rd);
      check({vecs[i].name, "_viral"}, {31'b0, viral[vecs[i].k]}, {31'b0, vecs[i].exp_viral});
      check({vecs[i].name, "_intr"},  {31'b0, intr[vecs[i].k]},  {31'b0, vecs[i].exp_intr});
      if (vecs[i].name == "we_re_c") check("we_re_c_mem_kept", u0.mem[3], 32'h1234_5678);
    end

    // Reset asserted in the middle of an 8-cycle read on u2
    req[2] = 1'b1; re[2] = 1'b1; raddr[2] = 32'h0;
    glat = 0;
    do begin
      step();
      glat++;
    end while (!gnt[2] && glat < 40);
    check("mid_rst_glat", 32'(glat), 32'd1);
    step();
    req[2] = 1'b0; re[2] = 1'b0;
    step();
    step();
    #2 rst = 1'b1;
    #1;
    $display("[TB] mid_rst: gnt=%0b rvalid=%0b rdata=%h intr=%0b viral=%0b",
             gnt[2], rvalid[2], rdata[2], intr[2], viral[2]);
    check("mid_rst_gnt",    {31'b0, gnt[2]},    32'd0);
    check("mid_rst_rvalid", {31'b0, rvalid[2]}, 32'd0);
    check("mid_rst_rdata",  rdata[2],           32'd0);
    check("mid_rst_intr",   {31'b0, intr[2]},   32'd0);
    check("mid_rst_viral",  {31'b0, viral[2]},  32'd0);
    step();
    step();
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      step();
      if (rvalid[2]) seen = 1'b1;
    end
    check("mid_rst_no_rvalid", {31'b0, seen}, 32'd0);
    txn(2, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, glat, rlat, rd);
    $display("[TB] post_rst_rd: u2 glat=%0d rlat=%0d rdata=%h viral=%0b", glat, rlat, rd, viral[2]);
    check("post_rst_glat",  32'(glat), 32'd1);
    check("post_rst_rlat",  32'(rlat), 32'd8);
    check("post_rst_rdata", rd,        32'd0);
    check("post_rst_viral", {31'b0, viral[2]}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
